// File: rtl/lcd_pkg.sv
// Shared types and geometry for the LCD framebuffer copier.
// 96x64 mono panel: 8 pages of 96 column bytes.
package lcd_pkg;

    localparam int          LCD_COLS        = 96;
    localparam int          LCD_PAGES       = 8;
    localparam int          FB_BYTES        = LCD_COLS * LCD_PAGES;
    localparam logic [23:0] FB_BASE_DEFAULT = 24'h001000;

    typedef logic [9:0] gdram_addr_t;
    typedef logic [2:0] page_t;
    typedef logic [6:0] col_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    function automatic gdram_addr_t page_col_addr(page_t p, col_t c);
        return gdram_addr_t'(p) * gdram_addr_t'(LCD_COLS)
             + gdram_addr_t'(c);
    endfunction

    function automatic page_t index_page(gdram_addr_t idx);
        page_t p;
        p = '0;
        for (int i = 1; i < LCD_PAGES; i++) begin
            if (idx >= gdram_addr_t'(i * LCD_COLS)) begin
                p = page_t'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/lcd_fb_copier_if.sv
// Bus bundle of the copier: CPU memory read side plus
// GDRAM port A write side.
interface lcd_fb_copier_if;
    import lcd_pkg::*;

    logic        bus_request;
    logic        bus_ack;
    logic [23:0] mem_address;
    logic        mem_read;
    logic [7:0]  mem_data_in;
    gdram_addr_t gdram_address;
    logic [7:0]  gdram_data;
    logic        gdram_we;

    modport master (
        output bus_request,
        output mem_address,
        output mem_read,
        output gdram_address,
        output gdram_data,
        output gdram_we,
        input  bus_ack,
        input  mem_data_in
    );

    modport slave (
        input  bus_request,
        input  mem_address,
        input  mem_read,
        input  gdram_address,
        input  gdram_data,
        input  gdram_we,
        output bus_ack,
        output mem_data_in
    );

endinterface

// File: rtl/lcd_page_col_counter.sv
// Read-side position of the copier as page/col plus linear index.
// Loadable from a linear index so a lost bus can rewind the stream.
module lcd_page_col_counter
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        incr,
    input  logic        load,
    input  gdram_addr_t load_index,
    output page_t       page,
    output col_t        col,
    output gdram_addr_t index,
    output logic        done
);

    page_t ld_page;

    assign ld_page = index_page(load_index);
    assign done    = (index == gdram_addr_t'(FB_BYTES));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            page  <= '0;
            col   <= '0;
            index <= '0;
        end else if (clear) begin
            page  <= '0;
            col   <= '0;
            index <= '0;
        end else if (load) begin
            page  <= ld_page;
            col   <= col_t'(load_index - page_col_addr(ld_page, '0));
            index <= load_index;
        end else if (incr) begin
            index <= index + 1'b1;
            if (col == col_t'(LCD_COLS - 1)) begin
                col  <= '0;
                page <= page + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_fb_copier.sv
// Copies the CPU framebuffer into LCD GDRAM port A, one byte per clk_ce.
// Optional LCD_COPY_INVERT_EN adds a per-frame invert input.
module lcd_fb_copier
    import lcd_pkg::*;
#(
    parameter logic [23:0] FB_BASE = FB_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_ce,
    input  logic              enable,
    input  logic              start,
`ifdef LCD_COPY_INVERT_EN
    input  logic              invert,
`endif
    lcd_fb_copier_if.master   bus,
    output logic              busy,
    output logic              frame_complete,
    output logic              overrun
);

    state_t      state;
    logic        req_q;
    logic        rd_q;
    logic [23:0] addr_q;
    gdram_addr_t gaddr_q;
    logic [7:0]  gdata_q;
    logic        we_q;
    logic        fc_q;
    logic        busy_q;
    logic        ovr_q;
    gdram_addr_t wr_index;
    gdram_addr_t pend_addr;
    logic [7:0]  mask;

    page_t       rd_page;
    col_t        rd_col;
    gdram_addr_t rd_index;
    logic        rd_done;

    logic        in_xfer;
    logic        accept;
    logic        issue_first;
    logic        issue_next;
    logic        lost;
    gdram_addr_t cur_addr;
    logic [23:0] rd_addr;

    assign in_xfer     = (state == READ) || (state == STREAM);
    assign accept      = clk_ce && (state == IDLE) && start && enable;
    assign issue_first = clk_ce && (state == REQ) && bus.bus_ack;
    assign issue_next  = clk_ce && in_xfer && bus.bus_ack && !rd_done;
    assign lost        = clk_ce && in_xfer && !bus.bus_ack;
    assign cur_addr    = page_col_addr(rd_page, rd_col);
    assign rd_addr     = FB_BASE + 24'(rd_index);

    lcd_page_col_counter u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (accept),
        .incr       (issue_first || issue_next),
        .load       (lost),
        .load_index (wr_index),
        .page       (rd_page),
        .col        (rd_col),
        .index      (rd_index),
        .done       (rd_done)
    );

`ifdef LCD_COPY_INVERT_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= invert;
        end
    end

    assign mask = {8{inv_q}};
`else
    assign mask = 8'h00;
`endif

    // Strobes stay registered across idle clk_ce gaps but are only
    // presented in cycles where clk_ce is high.
    assign bus.gdram_we     = we_q & clk_ce;
    assign frame_complete   = fc_q & clk_ce;
    assign bus.bus_request  = req_q;
    assign bus.mem_read     = rd_q;
    assign bus.mem_address  = addr_q;
    assign bus.gdram_address = gaddr_q;
    assign bus.gdram_data   = gdata_q;
    assign busy             = busy_q;
    assign overrun          = ovr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= FB_BASE;
            gaddr_q   <= '0;
            gdata_q   <= '0;
            we_q      <= 1'b0;
            fc_q      <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            wr_index  <= '0;
            pend_addr <= '0;
        end else if (clk_ce) begin
            we_q <= 1'b0;
            fc_q <= 1'b0;
            if (start && state != IDLE) begin
                ovr_q <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start && enable) begin
                        state    <= REQ;
                        req_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        ovr_q    <= 1'b0;
                        wr_index <= '0;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        state     <= READ;
                        rd_q      <= 1'b1;
                        addr_q    <= rd_addr;
                        pend_addr <= cur_addr;
                    end
                end
                READ, STREAM: begin
                    if (!bus.bus_ack) begin
                        // In-flight byte is dropped; counter rewinds to wr_index.
                        state <= REQ;
                        rd_q  <= 1'b0;
                    end else begin
                        we_q     <= 1'b1;
                        gdata_q  <= bus.mem_data_in ^ mask;
                        gaddr_q  <= pend_addr;
                        wr_index <= wr_index + 1'b1;
                        if (rd_done) begin
                            state <= DRAIN;
                            rd_q  <= 1'b0;
                        end else begin
                            state     <= STREAM;
                            addr_q    <= rd_addr;
                            pend_addr <= cur_addr;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    fc_q  <= 1'b1;
                    req_q <= 1'b0;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_fb_copier.sv
// Directed bench for lcd_fb_copier with a GDRAM write scoreboard.
// Define LCD_COPY_INVERT_EN to also exercise the invert input.
module tb_lcd_fb_copier;
    import lcd_pkg::*;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic clk_ce;
    logic enable;
    logic start;
`ifdef LCD_COPY_INVERT_EN
    logic invert;
`endif
    logic busy;
    logic frame_complete;
    logic overrun;

    lcd_fb_copier_if bus ();

    lcd_fb_copier dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk_ce         (clk_ce),
        .enable         (enable),
        .start          (start),
`ifdef LCD_COPY_INVERT_EN
        .invert         (invert),
`endif
        .bus            (bus),
        .busy           (busy),
        .frame_complete (frame_complete),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [FB_BYTES];
    logic [23:0] ma_off;

    assign ma_off = bus.mem_address - 24'h001000;
    assign bus.mem_data_in = (ma_off < 24'd768) ? ram[ma_off[9:0]] : 8'h00;

    exp_t sb[$];
    int   wcount [FB_BYTES];
    int   passed = 0;
    int   total = 0;
    int   fc_total = 0;
    int   wr_total = 0;
    int   exp_fc = 0;
    int   grant_delay = 0;
    int   gwait = 0;
    int   drop_cnt = 0;
    bit   ce_rand = 1'b0;
    logic ce_edge;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        ce_edge = clk_ce;
        @(posedge clk);
        #1;
        clk_ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (bus.gdram_we) begin
            wr_total++;
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.gdram_address), 32'(e.addr));
                chk("wr_data", 32'(bus.gdram_data), 32'(e.data));
                if (bus.gdram_address < 10'd768) begin
                    wcount[bus.gdram_address]++;
                end
            end
        end
        if (frame_complete) fc_total++;
        if (drop_cnt > 0) begin
            bus.bus_ack = 1'b0;
            drop_cnt--;
        end else if (!bus.bus_request) begin
            bus.bus_ack = 1'b0;
            gwait = 0;
        end else if (!bus.bus_ack) begin
            if (gwait >= grant_delay) bus.bus_ack = 1'b1;
            else gwait++;
        end
    endtask

    task automatic run_frame(input int delay, input bit inv,
                             input int drop_idx, input int ovr_idx,
                             input int abort_idx, input int lat);
        exp_t e;
        int   n;
        int   tk;
        int   k;
        int   bad;
        int   first_rd;
        int   fc_before;
        int   wr_before;
        bit   seen_fc;
        sb.delete();
        for (int i = 0; i < FB_BYTES; i++) begin
            wcount[i] = 0;
            e.addr = 10'(i);
            e.data = inv ? ~ram[i] : ram[i];
            sb.push_back(e);
        end
        grant_delay = delay;
`ifdef LCD_COPY_INVERT_EN
        invert = inv;
`endif
        fc_before = fc_total;
        enable = 1'b1;
        start  = 1'b1;
        clk_ce = 1'b1;
        tick();
        start = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ovr", 32'(overrun), 32'd0);
        n = 0;
        tk = 0;
        seen_fc = 1'b0;
        first_rd = -1;
        while (!seen_fc && n < 3000 && tk < 12000) begin
            tick();
            tk++;
            n += int'(ce_edge);
            if (bus.mem_read && first_rd < 0) first_rd = n;
            if (bus.gdram_we && int'(bus.gdram_address) == abort_idx) begin
                reset_n = 1'b0;
                tick();
                chk("rst_req", 32'(bus.bus_request), 32'd0);
                chk("rst_rd", 32'(bus.mem_read), 32'd0);
                chk("rst_maddr", 32'(bus.mem_address), 32'h1000);
                chk("rst_gaddr", 32'(bus.gdram_address), 32'd0);
                chk("rst_gdata", 32'(bus.gdram_data), 32'd0);
                chk("rst_we", 32'(bus.gdram_we), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_fc", 32'(frame_complete), 32'd0);
                chk("rst_ovr", 32'(overrun), 32'd0);
                sb.delete();
                reset_n = 1'b1;
                wr_before = wr_total;
                repeat (20) tick();
                chk("no_we_after_rst", 32'(wr_total - wr_before), 32'd0);
                chk("idle_after_rst", 32'(busy), 32'd0);
                return;
            end
            if (bus.gdram_we && int'(bus.gdram_address) == drop_idx) begin
                bus.bus_ack = 1'b0;
                drop_cnt = 2;
            end
            if (bus.gdram_we && int'(bus.gdram_address) == ovr_idx) begin
                start = 1'b1;
                tick();
                n += int'(ce_edge);
                start = 1'b0;
                chk("overrun_set", 32'(overrun), 32'd1);
                chk("overrun_busy", 32'(busy), 32'd1);
            end
            if (frame_complete) seen_fc = 1'b1;
        end
        chk("frame_done", 32'(seen_fc), 32'd1);
        if (lat > 0) begin
            chk("latency", 32'(n), 32'(lat));
            chk("first_read", 32'(first_rd), 32'(delay + 1));
        end
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_req", 32'(bus.bus_request), 32'd0);
        chk("fc_once", 32'(fc_total - fc_before), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < FB_BYTES; i++) begin
            if (wcount[i] != 1) bad++;
        end
        chk("write_once", 32'(bad), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        clk_ce = 1'b1;
        enable = 1'b0;
        start = 1'b0;
        bus.bus_ack = 1'b0;
`ifdef LCD_COPY_INVERT_EN
        invert = 1'b0;
`endif
        for (int i = 0; i < FB_BYTES; i++) ram[i] = 8'(i);
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req", 32'(bus.bus_request), 32'd0);
        chk("reset_rd", 32'(bus.mem_read), 32'd0);
        chk("reset_maddr", 32'(bus.mem_address), 32'h1000);
        chk("reset_we", 32'(bus.gdram_we), 32'd0);
        chk("reset_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("disabled_busy", 32'(busy), 32'd0);
        chk("disabled_req", 32'(bus.bus_request), 32'd0);

        run_frame(0, 1'b0, -1, -1, -1, 770);
        exp_fc++;
        run_frame(5, 1'b0, -1, -1, -1, 775);
        exp_fc++;
        run_frame(0, 1'b0, 200, -1, -1, -1);
        exp_fc++;
        run_frame(0, 1'b0, -1, 400, -1, 770);
        exp_fc++;
        chk("overrun_sticky", 32'(overrun), 32'd1);
        run_frame(0, 1'b0, -1, -1, 100, -1);

        for (int i = 0; i < FB_BYTES; i++) ram[i] = 8'($urandom);
        ce_rand = 1'b1;
        run_frame(0, 1'b0, -1, -1, -1, 770);
        exp_fc++;
        ce_rand = 1'b0;

`ifdef LCD_COPY_INVERT_EN
        ram[0] = 8'h5A;
        run_frame(0, 1'b1, -1, -1, -1, 770);
        exp_fc++;
        run_frame(0, 1'b0, -1, -1, -1, 770);
        exp_fc++;
`endif

        chk("fc_total", 32'(fc_total), 32'(exp_fc));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lcd_fb_copier.md
Name: lcd_fb_copier

Overview:
- Writer side of the LCD scan-out path: copies the 768-byte CPU framebuffer (system RAM, 0x1000–0x12FF) into the LCD GDRAM dual-port RAM.
- The video timing generator reads port B of that same GDRAM, so a frame is displayed only after this block has written it.
- Runs in clk_sys, paced by the CPU clock enable.
- Gains the memory bus through the bus_request/bus_ack handshake, reads sequentially, and writes each byte into GDRAM port A.

Parameters:
- FB_BASE, 24'h1000, absolute address of framebuffer byte 0 in the CPU memory map.
- LCD_COLS, 96, columns per page.
- LCD_PAGES, 8, pages of 8 pixel rows each.
- FB_BYTES, LCD_COLS*LCD_PAGES (768), bytes transferred per frame.

Ports:
- clk  in  1  system clock (clk_sys).
- reset_n  in  1  synchronous reset, active low.
- clk_ce  in  1  clock enable; the FSM and counters advance only when clk_ce=1.
- enable  in  1  copy enable; when low, start is ignored.
- start  in  1  one-cycle frame-copy request, sampled when clk_ce=1.
- bus_request  out  1  request for the memory bus.
- bus_ack  in  1  bus granted.
- mem_address  out  24  read address, FB_BASE + index.
- mem_read  out  1  read strobe.
- mem_data_in  in  8  read data, valid one clk_ce cycle after its address.
- gdram_address  out  10  GDRAM write address, page*LCD_COLS + col.
- gdram_data  out  8  GDRAM write data.
- gdram_we  out  1  GDRAM write strobe, one clk cycle wide, asserted only in a clk_ce cycle.
- busy  out  1  high from leaving IDLE until re-entering IDLE.
- frame_complete  out  1  one-clk pulse after the last GDRAM write.
- overrun  out  1  sticky; set when start arrives while busy; cleared by reset or by an accepted start.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FSM enters IDLE; index, page and col counters go to 0.
  - Every output goes to 0, and mem_address goes to FB_BASE.
  - Reset applied mid-copy abandons the copy; no further gdram_we is issued.
- Counters:
  - index is 10 bits, 0..767.
  - col counts 0..LCD_COLS-1 and wraps to 0, incrementing page.
  - page counts 0..LCD_PAGES-1.
  - gdram_address always equals page*LCD_COLS + col of the byte being written, which is numerically the index of that byte.
- FSM states (all transitions happen only on clk_ce=1):
  - IDLE: on start & enable, go to REQ and clear overrun. start while enable=0 is dropped.
  - REQ: drive bus_request=1 and wait for bus_ack=1, then go to READ.
  - READ: drive mem_read=1 and mem_address=FB_BASE+rd_index; advance rd_index; go to STREAM.
  - STREAM: pipelined, one byte per clk_ce.
    - The data for rd_index-1 is written to GDRAM (gdram_we).
    - The read for rd_index is issued in the same clk_ce cycle.
    - After the read for index 767 is issued, go to DRAIN.
  - DRAIN: write the final byte (index 767), then go to DONE.
  - DONE: pulse frame_complete, drop bus_request, go to IDLE.
- Copy duration: 1 REQ-grant cycle + 768 reads + 1 drain cycle. With a grant on the first REQ cycle, the copy takes exactly 770 clk_ce cycles from start to frame_complete.
- Bus loss: if bus_ack drops in READ, STREAM or DRAIN:
  - In the cycle bus_ack is low, issue no write and no read; the byte whose data would be returned is discarded.
  - Move to REQ with bus_request held high.
  - rd_index rewinds to the oldest index not yet written.
  - On re-grant the copy resumes from that index; no byte is skipped or written twice.
- start while busy: ignored and sets overrun=1. The copy in progress is unaffected.
- start and the last DRAIN write in the same cycle: the start is ignored and sets overrun.
- clk_ce=0: all state and outputs hold, except gdram_we and frame_complete, which are forced low.

Optional Feature:
- Macro LCD_COPY_INVERT_EN.
- Defined:
  - Extra input port invert (1 bit), sampled when the copy is accepted in IDLE and held for the whole frame.
  - If invert=1, gdram_data = ~mem_data_in.
- Undefined: the port is absent and data passes through unchanged.

Decomposition:
- Package lcd_pkg holds:
  - State enum: IDLE, REQ, READ, STREAM, DRAIN, DONE.
  - Localparams LCD_COLS, LCD_PAGES, FB_BYTES, FB_BASE_DEFAULT.
  - The 10-bit gdram_addr_t typedef.
- One sub-module: lcd_page_col_counter, a loadable page/col counter. It provides clear, increment, and load-from-index for the rewind.

Test Plan:
- Fill RAM[0x1000+i] = i[7:0] (i = 0..767); start with immediate grant → 768 GDRAM writes, addr i, data i[7:0]; frame_complete exactly 770 clk_ce cycles after start; busy low afterwards.
- Grant delayed 5 clk_ce cycles → no mem_read until bus_ack; total latency 775 clk_ce cycles; data identical to the first test.
- Drop bus_ack for 3 clk_ce cycles after write of index 200 → resume at 201; every address 0..767 written exactly once; GDRAM contents match RAM.
- start pulsed at index 400 → overrun=1; a single frame_complete; next start accepted with overrun cleared.
- reset_n=0 at index 100 → all outputs 0 next cycle; no gdram_we afterwards; new start copies from index 0.
- LCD_COPY_INVERT_EN defined, invert=1, RAM byte 0x5A → gdram_data 0xA5; invert=0 → 0x5A.
